// File: rtl/ram_program_loader.sv
// Host-side loader that writes a program image into the CPU's RAM over the shared bus.
// Holds the CPU in reset while a session is active; each host byte becomes an address load, a data load and a RAM write.
module ram_program_loader #(
  parameter int ADDR_WIDTH  = 4,
  parameter int RAM_BYTES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_en,
  input  logic                  prog_strobe,
  input  logic [7:0]            prog_data,
  output logic                  prog_ack,
  output logic [7:0]            bus_out,
  output logic                  bus_oe,
  output logic                  n_load_addr,
  output logic                  n_load_data,
  output logic                  ram_we_n,
  output logic                  cpu_rst_n,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            checksum,
  output logic                  done
);

  localparam int CNT_W = $clog2(RAM_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STB,
    LOAD_ADDR,
    LOAD_DATA,
    WRITE,
    ACK,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  en_sync_q, stb_sync_q;
  logic                    stb_prev_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              chk_q, chk_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    abort_q, abort_d;
  logic                    cpu_rst_q;
  logic [7:0]              byte_q;
  logic                    capture;
  logic                    en_s, stb_s, stb_rise;

  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_sync_q  <= '0;
      stb_sync_q <= '0;
      stb_prev_q <= 1'b0;
      state_q    <= IDLE;
      addr_q     <= '0;
      chk_q      <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], prog_en};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], prog_strobe};
      stb_prev_q <= stb_s;
      state_q    <= state_d;
      addr_q     <= addr_d;
      chk_q      <= chk_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      cpu_rst_q  <= (state_q == IDLE);
    end
  end

  // The byte register only feeds the bus in LOAD_DATA, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      byte_q <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d = WAIT_STB;
          addr_d  = '0;
          chk_d   = '0;
          cnt_d   = '0;
        end
      end
      WAIT_STB: begin
        if (!en_s) begin
          state_d = IDLE;
        end else if (stb_rise) begin
          state_d = LOAD_ADDR;
          capture = 1'b1;
        end
      end
      LOAD_ADDR: state_d = LOAD_DATA;
      LOAD_DATA: state_d = WRITE;
      WRITE: begin
        state_d = ACK;
        chk_d   = chk_q + byte_q;
        abort_d = ~en_s;
      end
      ACK: begin
        // An enable drop seen before ACK still retires the byte; a drop during ACK needs the strobe low too.
        if (abort_q || !en_s) begin
          state_d = IDLE;
          if (abort_q || !stb_s) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end else if (!stb_s) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_W'(RAM_BYTES - 1)) ? DONE : WAIT_STB;
        end
      end
      DONE: begin
        if (!en_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_out     = 8'h00;
    bus_oe      = 1'b0;
    n_load_addr = 1'b1;
    n_load_data = 1'b1;
    ram_we_n    = 1'b1;
    prog_ack    = 1'b0;
    done        = 1'b0;
    case (state_q)
      LOAD_ADDR: begin
        bus_out     = 8'(addr_q);
        bus_oe      = 1'b1;
        n_load_addr = 1'b0;
      end
      LOAD_DATA: begin
        bus_out     = byte_q;
        bus_oe      = 1'b1;
        n_load_data = 1'b0;
      end
      WRITE:   ram_we_n = 1'b0;
      ACK:     prog_ack = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rst_n = cpu_rst_q;
  assign addr      = addr_q;
  assign checksum  = chk_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: stimulus queues the expected bus events,
// a negedge monitor pops and compares them as the loader produces them.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_en;
  logic       prog_strobe;
  logic [7:0] prog_data;
  logic       prog_ack;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       n_load_addr;
  logic       n_load_data;
  logic       ram_we_n;
  logic       cpu_rst_n;
  logic [3:0] addr;
  logic [7:0] checksum;
  logic       done;

  ram_program_loader #(.ADDR_WIDTH(4), .RAM_BYTES(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_strobe(prog_strobe),
    .prog_data(prog_data), .prog_ack(prog_ack), .bus_out(bus_out), .bus_oe(bus_oe),
    .n_load_addr(n_load_addr), .n_load_data(n_load_data), .ram_we_n(ram_we_n),
    .cpu_rst_n(cpu_rst_n), .addr(addr), .checksum(checksum), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;   // 0 addr load, 1 data load, 2 RAM write, 3 ack rise
    logic [7:0] bus;
    logic [7:0] chk;
  } ev_t;

  ev_t expq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc_cnt = 0;

  logic [3:0] m_addr;
  logic [7:0] m_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] bus, input logic [7:0] chk);
    ev_t e;
    e.kind = kind;
    e.bus  = bus;
    e.chk  = chk;
    expq.push_back(e);
  endtask

  task automatic wait_ack(input logic level);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (prog_ack === level) ok = 1;
    end
    check("ack_wait_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_bus_oe", bus_oe, 1'b0);
    check("rst_n_load_addr", n_load_addr, 1'b1);
    check("rst_n_load_data", n_load_data, 1'b1);
    check("rst_ram_we_n", ram_we_n, 1'b1);
    check("rst_prog_ack", prog_ack, 1'b0);
    check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    check("rst_addr", addr, 4'h0);
    check("rst_checksum", checksum, 8'h00);
    check("rst_done", done, 1'b0);
  endtask

  task automatic start_session();
    prog_en = 1'b1;
    cyc(4);
    m_addr = 4'h0;
    m_chk  = 8'h00;
  endtask

  task automatic end_session();
    prog_en = 1'b0;
    cyc(5);
  endtask

  task automatic send_byte(input logic [7:0] b);
    prog_data = b;
    push_ev(2'd0, {4'h0, m_addr}, 8'h00);
    push_ev(2'd1, b, 8'h00);
    push_ev(2'd2, 8'h00, 8'h00);
    m_chk = m_chk + b;
    push_ev(2'd3, 8'h00, m_chk);
    prog_strobe = 1'b1;
    wait_ack(1'b1);
    prog_strobe = 1'b0;
    wait_ack(1'b0);
    m_addr = m_addr + 4'h1;
    @(negedge clk);
    check("addr_after_byte", addr, m_addr);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic ack_prev = 1'b0;
  int   last_cyc = 0;

  always @(negedge clk) begin
    logic la, ld, wr, ackr;
    logic [1:0] kind;
    ev_t e;
    la   = !n_load_addr;
    ld   = !n_load_data;
    wr   = !ram_we_n;
    ackr = prog_ack && !ack_prev;
    vectors++;
    if ($countones({la, ld, wr}) > 1 || (bus_oe && !(la || ld)) || ((la || ld || wr) && cpu_rst_n)) begin
      miscompares++;
      $display("FAIL protocol: la=%b ld=%b we=%b oe=%b cpu_rst_n=%b", la, ld, wr, bus_oe, cpu_rst_n);
    end
    if (la || ld || wr || ackr) begin
      kind = la ? 2'd0 : ld ? 2'd1 : wr ? 2'd2 : 2'd3;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
      end else begin
        e = expq.pop_front();
        check("event_kind", kind, e.kind);
        if (e.kind == 2'd0 || e.kind == 2'd1) begin
          check("event_bus_out", bus_out, e.bus);
          check("event_bus_oe", bus_oe, 1'b1);
        end
        if (e.kind == 2'd3) check("ack_checksum", checksum, e.chk);
        if (e.kind != 2'd0) check("event_spacing", cyc_cnt - last_cyc, 1);
      end
      last_cyc = cyc_cnt;
    end
    ack_prev = prog_ack;
  end

  initial begin
    rst_n       = 1'b0;
    prog_en     = 1'b0;
    prog_strobe = 1'b0;
    prog_data   = 8'h00;
    m_addr      = 4'h0;
    m_chk       = 8'h00;

    // Reset values, then CPU reset release after reset deasserts
    repeat (3) @(posedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);
    @(negedge clk);
    check("cpu_rst_release", cpu_rst_n, 1'b1);
    check("idle_bus_oe", bus_oe, 1'b0);

    // Single byte 0xA5
    start_session();
    @(negedge clk);
    check("cpu_held_in_session", cpu_rst_n, 1'b0);
    send_byte(8'hA5);
    check("single_checksum", checksum, 8'hA5);
    check("single_cpu_rst", cpu_rst_n, 1'b0);
    end_session();
    @(negedge clk);
    check("cpu_rst_after_session", cpu_rst_n, 1'b1);

    // Full 16-byte image, then an ignored 17th strobe
    start_session();
    for (int i = 1; i <= 16; i++) send_byte(i[7:0]);
    check("full_done", done, 1'b1);
    check("full_checksum", checksum, 8'h88);
    prog_data   = 8'h77;
    prog_strobe = 1'b1;
    cyc(12);
    @(negedge clk);
    check("done_ignores_ack", prog_ack, 1'b0);
    check("done_holds", done, 1'b1);
    check("done_checksum_holds", checksum, 8'h88);
    prog_strobe = 1'b0;
    end_session();
    @(negedge clk);
    check("done_to_idle_cpu", cpu_rst_n, 1'b1);
    check("done_cleared", done, 1'b0);

    // Strobe held high for 20 cycles
    start_session();
    prog_data = 8'h3C;
    push_ev(2'd0, 8'h00, 8'h00);
    push_ev(2'd1, 8'h3C, 8'h00);
    push_ev(2'd2, 8'h00, 8'h00);
    push_ev(2'd3, 8'h00, 8'h3C);
    prog_strobe = 1'b1;
    cyc(20);
    @(negedge clk);
    check("held_ack_high", prog_ack, 1'b1);
    check("held_addr_not_advanced", addr, 4'h0);
    prog_strobe = 1'b0;
    wait_ack(1'b0);
    @(negedge clk);
    check("held_addr_after_drop", addr, 4'h1);
    check("held_checksum", checksum, 8'h3C);
    end_session();

    // prog_en dropped during LOAD_DATA
    start_session();
    prog_data = 8'h5A;
    push_ev(2'd0, 8'h00, 8'h00);
    push_ev(2'd1, 8'h5A, 8'h00);
    push_ev(2'd2, 8'h00, 8'h00);
    push_ev(2'd3, 8'h00, 8'h5A);
    prog_strobe = 1'b1;
    cyc(2);
    prog_en = 1'b0;
    cyc(5);
    @(negedge clk);
    check("abort_ack_low", prog_ack, 1'b0);
    check("abort_addr_incr", addr, 4'h1);
    prog_strobe = 1'b0;
    cyc(2);
    @(negedge clk);
    check("abort_cpu_rst", cpu_rst_n, 1'b1);
    start_session();
    @(negedge clk);
    check("reenable_addr", addr, 4'h0);
    check("reenable_checksum", checksum, 8'h00);

    // rst_n asserted during LOAD_ADDR
    prog_data = 8'hC3;
    push_ev(2'd0, 8'h00, 8'h00);
    prog_strobe = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    check_reset_values();
    cyc(5);
    prog_strobe = 1'b0;
    prog_en     = 1'b0;
    rst_n       = 1'b1;
    cyc(4);

    check("events_outstanding", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
